vl_pipe_elastic: RTL and testbench

Parametrised elastic pipeline: a PIPE_DEPTH-stage, PIPE_DW-wide register pipeline with a valid/ready handshake on both ends, backpressure, synchronous flush and an occupancy count. It succeeds the free-running fixed delay line. Use it wherever a datapath needs a fixed register depth and must also stall: between producer/consumer blocks and on timing-closure cut points. A mode parameter selects either bubble-collapsing per-stage stalls or a whole-pipe global stall.

---
 rtl/vl_pipe_pkg.sv | 11 +
 rtl/vl_pipe_stage.sv | 49 ++++
 rtl/vl_pipe_elastic.sv | 86 ++++++++
 tb/tb_vl_pipe_elastic.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vl_pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package vl_pipe_pkg;

    localparam int VL_PIPE_GLOBAL   = 0;
    localparam int VL_PIPE_COLLAPSE = 1;

    function automatic int vl_pipe_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vl_pipe_stage.sv
// One register slice of the elastic pipeline: a valid bit plus a data word
// that only captures on a valid load and is left alone by flush.
module vl_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic          load_i,
    input  logic          up_valid_i,
    input  logic [DW-1:0] up_data_i,
    input  logic          down_ready_i,
    output logic          v_o,
    output logic [DW-1:0] d_o,
    output logic          ready_o
);

    logic          v_q, v_d;
    logic [DW-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else if (load_i) begin
            v_d = up_valid_i;
            // Bubbles never overwrite the held word.
            if (up_valid_i) begin
                d_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o     = v_q;
    assign d_o     = d_q;
    assign ready_o = !v_q || down_ready_i;

endmodule

// File: rtl/vl_pipe_elastic.sv
// Elastic PIPE_DEPTH-stage pipeline with valid/ready on both ends, flush and
// occupancy; COLLAPSE picks per-stage stalls or a single global advance.
module vl_pipe_elastic
    import vl_pipe_pkg::*;
#(
    parameter int PIPE_DEPTH = 2,
    parameter int PIPE_DW    = 8,
    parameter int COLLAPSE   = VL_PIPE_COLLAPSE
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [PIPE_DW-1:0]                      in_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [PIPE_DW-1:0]                      out_data,
    output logic [vl_pipe_cnt_w(PIPE_DEPTH)-1:0]    occupancy
);

    localparam int CNT_W = vl_pipe_cnt_w(PIPE_DEPTH);

    if (PIPE_DEPTH < 1) begin : g_bad_depth
        $error("vl_pipe_elastic: PIPE_DEPTH must be >= 1");
    end
    if (COLLAPSE != VL_PIPE_GLOBAL && COLLAPSE != VL_PIPE_COLLAPSE) begin : g_bad_mode
        $error("vl_pipe_elastic: COLLAPSE must be 0 or 1");
    end

    logic [PIPE_DEPTH-1:0] v;
    logic [PIPE_DEPTH-1:0] r;
    logic [PIPE_DEPTH-1:0] load;
    logic [PIPE_DW-1:0]    d [PIPE_DEPTH];
    logic                  adv;

    assign adv = out_ready || !v[0];

    // Stage k-1 is downstream of stage k; the top stage is fed by the producer.
    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        logic               up_valid;
        logic [PIPE_DW-1:0] up_data;
        logic               down_ready;

        if (k == PIPE_DEPTH - 1) begin : g_top
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_mid
            assign up_valid = v[k+1];
            assign up_data  = d[k+1];
        end

        if (k == 0) begin : g_out
            assign down_ready = out_ready;
        end else begin : g_chain
            assign down_ready = r[k-1];
        end

        assign load[k] = (COLLAPSE == VL_PIPE_COLLAPSE) ? r[k] : adv;

        vl_pipe_stage #(.DW(PIPE_DW)) u_stage (
            .clk_i        (clk),
            .reset_i      (reset),
            .flush_i      (flush),
            .load_i       (load[k]),
            .up_valid_i   (up_valid),
            .up_data_i    (up_data),
            .down_ready_i (down_ready),
            .v_o          (v[k]),
            .d_o          (d[k]),
            .ready_o      (r[k])
        );
    end

    assign in_ready  = (COLLAPSE == VL_PIPE_COLLAPSE) ? r[PIPE_DEPTH-1] : adv;
    assign out_valid = v[0];
    assign out_data  = d[0];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            occupancy = occupancy + CNT_W'(v[k]);
        end
    end

endmodule

// File: tb/tb_vl_pipe_elastic.sv
// Bench for vl_pipe_elastic: four configurations share one stimulus bus, and
// a FIFO scoreboard follows whichever instance is selected.
module tb_vl_pipe_elastic;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       a_in_ready, b_in_ready, g_in_ready, f_in_ready;
    logic       a_out_valid, b_out_valid, g_out_valid, f_out_valid;
    logic [7:0] a_out_data, b_out_data, g_out_data, f_out_data;
    logic [1:0] a_occ, f_occ;
    logic [2:0] b_occ, g_occ;

    logic       m_in_ready, m_out_valid;
    logic [7:0] m_out_data;
    logic [2:0] m_occ;
    int         sel;

    int         errors;
    int         checks;
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vl_pipe_elastic #(.PIPE_DEPTH(3), .PIPE_DW(8), .COLLAPSE(1)) u_d3 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .occupancy(a_occ));

    vl_pipe_elastic #(.PIPE_DEPTH(4), .PIPE_DW(8), .COLLAPSE(1)) u_d4c (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .occupancy(b_occ));

    vl_pipe_elastic #(.PIPE_DEPTH(4), .PIPE_DW(8), .COLLAPSE(0)) u_d4g (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(g_in_ready),
        .in_data(in_data), .out_valid(g_out_valid), .out_ready(out_ready),
        .out_data(g_out_data), .occupancy(g_occ));

    vl_pipe_elastic #(.PIPE_DEPTH(2), .PIPE_DW(8), .COLLAPSE(1)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(f_in_ready),
        .in_data(in_data), .out_valid(f_out_valid), .out_ready(out_ready),
        .out_data(f_out_data), .occupancy(f_occ));

    always_comb begin
        case (sel)
            0: begin
                m_in_ready = a_in_ready; m_out_valid = a_out_valid;
                m_out_data = a_out_data; m_occ = {1'b0, a_occ};
            end
            1: begin
                m_in_ready = b_in_ready; m_out_valid = b_out_valid;
                m_out_data = b_out_data; m_occ = b_occ;
            end
            2: begin
                m_in_ready = g_in_ready; m_out_valid = g_out_valid;
                m_out_data = g_out_data; m_occ = g_occ;
            end
            default: begin
                m_in_ready = f_in_ready; m_out_valid = f_out_valid;
                m_out_data = f_out_data; m_occ = {1'b0, f_occ};
            end
        endcase
    end

    // Scoreboard: accepted words are queued, delivered words must match in order.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (m_out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %h want no output", m_out_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (m_out_data !== e) begin
                        errors++;
                        $display("FAIL sb_order: got %h want %h", m_out_data, e);
                    end
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && m_in_ready) exp_q.push_back(in_data);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (8) next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d words left want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        sel = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (m_out_valid !== 1'b0 || m_out_data !== 8'h00 || m_occ !== 3'd0 || m_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold: got v=%b d=%h occ=%0d rdy=%b want v=0 d=00 occ=0 rdy=1",
                         m_out_valid, m_out_data, m_occ, m_in_ready);
            end
        end
        reset = 1'b0; in_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (m_out_valid !== 1'b0 || m_out_data !== 8'h00 || m_occ !== 3'd0 || m_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_after: got v=%b d=%h occ=%0d rdy=%b want v=0 d=00 occ=0 rdy=1",
                     m_out_valid, m_out_data, m_occ, m_in_ready);
        end
    endtask

    task automatic test_streaming();
        sel = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            int pushed, popped;
            in_valid = (i < 10);
            in_data  = 8'(i + 1);
            @(negedge clk);
            pushed = (i < 10) ? i : 10;
            popped = (i < 3) ? 0 : ((i - 3 > 10) ? 10 : i - 3);
            checks++;
            if (m_occ !== 3'(pushed - popped)) begin
                errors++;
                $display("FAIL stream_occ: cycle %0d got %0d want %0d", i, m_occ, pushed - popped);
            end
            checks++;
            if (m_out_valid !== (i >= 3 && i < 13)) begin
                errors++;
                $display("FAIL stream_valid: cycle %0d got %b want %b", i, m_out_valid, (i >= 3 && i < 13));
            end else if (i >= 3 && i < 13 && m_out_data !== 8'(i - 2)) begin
                errors++;
                $display("FAIL stream_data: cycle %0d got %h want %h", i, m_out_data, 8'(i - 2));
            end
            if (i < 10) begin
                checks++;
                if (m_in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready: cycle %0d got %b want 1", i, m_in_ready);
                end
            end
            next_cycle();
        end
        drain("stream");
    endtask

    task automatic push_one(input logic [7:0] data, input string name);
        in_valid = 1'b1; in_data = data;
        @(negedge clk);
        checks++;
        if (m_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_push: word %h got in_ready=%b want 1", name, data, m_in_ready);
        end
        next_cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_collapse_backpressure();
        int got;
        sel = 1;
        do_reset();
        out_ready = 1'b0;
        push_one(8'hA1, "collapse");
        repeat (2) next_cycle();
        push_one(8'hA2, "collapse");
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (m_occ !== 3'd2 || m_out_valid !== 1'b1 || m_out_data !== 8'hA1) begin
            errors++;
            $display("FAIL collapse_compact: got occ=%0d v=%b d=%h want occ=2 v=1 d=a1",
                     m_occ, m_out_valid, m_out_data);
        end
        next_cycle();
        push_one(8'hA3, "collapse");
        push_one(8'hA4, "collapse");
        in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk);
        checks++;
        if (m_occ !== 3'd4 || m_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL collapse_full: got occ=%0d rdy=%b want occ=4 rdy=0", m_occ, m_in_ready);
        end
        next_cycle();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL collapse_full_pop: got rdy=%b want 1", m_in_ready);
        end
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (m_out_valid === 1'b1) begin
                checks++;
                if (m_out_data !== 8'(8'hA1 + got)) begin
                    errors++;
                    $display("FAIL collapse_order: got %h want %h", m_out_data, 8'(8'hA1 + got));
                end
                got++;
            end
            next_cycle();
            in_valid = 1'b0;
        end
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL collapse_count: got %0d words want 5", got);
        end
        drain("collapse");
    endtask

    task automatic test_global_stall();
        logic [9:0] exp_v;
        int         exp_occ [10];
        sel = 2;
        do_reset();
        exp_v   = 10'b01_0111_0000;
        exp_occ = '{0, 1, 1, 2, 2, 2, 2, 1, 1, 0};
        for (int i = 0; i < 10; i++) begin
            in_valid  = (i == 0 || i == 2);
            in_data   = (i == 0) ? 8'hB1 : 8'hB2;
            out_ready = !(i == 4 || i == 5);
            @(negedge clk);
            checks++;
            if (m_out_valid !== exp_v[i] || m_occ !== 3'(exp_occ[i])) begin
                errors++;
                $display("FAIL global_state: cycle %0d got v=%b occ=%0d want v=%b occ=%0d",
                         i, m_out_valid, m_occ, exp_v[i], exp_occ[i]);
            end
            if (exp_v[i]) begin
                checks++;
                if (m_out_data !== ((i == 8) ? 8'hB2 : 8'hB1)) begin
                    errors++;
                    $display("FAIL global_data: cycle %0d got %h want %h",
                             i, m_out_data, (i == 8) ? 8'hB2 : 8'hB1);
                end
            end
            checks++;
            if (m_in_ready !== out_ready) begin
                errors++;
                $display("FAIL global_ready: cycle %0d got %b want %b", i, m_in_ready, out_ready);
            end
            next_cycle();
        end
        drain("global");
    endtask

    task automatic test_flush_collision();
        sel = 3;
        do_reset();
        out_ready = 1'b0;
        push_one(8'hC1, "flush");
        push_one(8'hC2, "flush");
        @(negedge clk);
        checks++;
        if (m_occ !== 3'd2 || m_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: got occ=%0d rdy=%b want occ=2 rdy=0", m_occ, m_in_ready);
        end
        next_cycle();
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hC3; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_in_ready !== 1'b1 || m_out_valid !== 1'b1 || m_out_data !== 8'hC1) begin
            errors++;
            $display("FAIL flush_cycle: got rdy=%b v=%b d=%h want rdy=1 v=1 d=c1",
                     m_in_ready, m_out_valid, m_out_data);
        end
        next_cycle();
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (m_out_valid !== 1'b0 || m_occ !== 3'd0) begin
                errors++;
                $display("FAIL flush_after: cycle %0d got v=%b occ=%0d d=%h want v=0 occ=0",
                         i, m_out_valid, m_occ, m_out_data);
            end
            next_cycle();
        end
        drain("flush");
    endtask

    task automatic test_reset_mid_stream();
        logic [7:0] word;
        sel = 0;
        do_reset();
        word = 8'h30;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = word; out_ready = (i % 2 == 0);
            @(negedge clk);
            if (m_in_ready) word = word + 8'd1;
            next_cycle();
        end
        reset = 1'b1; in_data = word; out_ready = 1'b0;
        next_cycle();
        reset = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 7; j++) begin
            in_valid = 1'b1; in_data = 8'(8'h50 + j);
            @(negedge clk);
            if (j == 0) begin
                checks++;
                if (m_out_valid !== 1'b0 || m_occ !== 3'd0 || m_out_data !== 8'h00) begin
                    errors++;
                    $display("FAIL midreset_clear: got v=%b occ=%0d d=%h want v=0 occ=0 d=00",
                             m_out_valid, m_occ, m_out_data);
                end
            end
            checks++;
            if (m_out_valid !== (j >= 3)) begin
                errors++;
                $display("FAIL midreset_latency: cycle %0d got v=%b want %b", j, m_out_valid, (j >= 3));
            end else if (j >= 3 && m_out_data !== 8'(8'h50 + j - 3)) begin
                errors++;
                $display("FAIL midreset_data: cycle %0d got %h want %h", j, m_out_data, 8'(8'h50 + j - 3));
            end
            next_cycle();
        end
        drain("midreset");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        sel    = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_collapse_backpressure();
        test_global_stall();
        test_flush_collision();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
